// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencer: FSM states, default
// prices, product index width and saturating 3-bit credit arithmetic.
package vend_pkg;

  localparam int PROD_W     = 2;
  localparam int CREDIT_W   = 3;
  localparam int DEF_PRICE0 = 2;
  localparam int DEF_PRICE1 = 3;
  localparam int DEF_PRICE2 = 5;

  localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CREDIT,
    ST_CHECK,
    ST_DISPENSE,
    ST_CHANGE,
    ST_REFUND
  } state_t;

  function automatic logic [CREDIT_W-1:0] sat_add(input logic [CREDIT_W-1:0] a,
                                                  input logic [CREDIT_W-1:0] b);
    logic [CREDIT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CREDIT_W] ? CREDIT_MAX : s[CREDIT_W-1:0];
  endfunction

  function automatic logic [CREDIT_W-1:0] sat_sub(input logic [CREDIT_W-1:0] a,
                                                  input logic [CREDIT_W-1:0] b);
    return (a >= b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter. Search starts one past the last granted
// index; the pointer only moves when the owner confirms a grant was used.
module rr_arbiter3
  import vend_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ena,
  input  logic [2:0]        i_req,
  input  logic              i_upd,
  input  logic [PROD_W-1:0] i_upd_idx,
  output logic              o_gnt_vld,
  output logic [PROD_W-1:0] o_gnt
);

  logic [PROD_W-1:0] r_last;
  logic [2:0]        w_pos;

  // Walk from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    o_gnt_vld = 1'b0;
    o_gnt     = '0;
    w_pos     = '0;
    for (int k = 2; k >= 0; k--) begin
      w_pos = {1'b0, r_last} + 3'd1 + 3'(k);
      if (w_pos >= 3'd3) w_pos = w_pos - 3'd3;
      if (w_pos >= 3'd3) w_pos = w_pos - 3'd3;
      if (i_req[w_pos[1:0]]) begin
        o_gnt_vld = 1'b1;
        o_gnt     = w_pos[PROD_W-1:0];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= PROD_W'(2);
    end else if (i_ena && i_upd) begin
      r_last <= i_upd_idx;
    end
  end

endmodule

// File: rtl/vend_sequencer.sv
// Coin-operated vending sequencer: counts coin edges into credit, arbitrates
// product requests, drives the dispenser handshake and pays out change.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int PRICE0       = DEF_PRICE0,
  parameter int PRICE1       = DEF_PRICE1,
  parameter int PRICE2       = DEF_PRICE2,
  parameter int IDLE_TIMEOUT = 200,
  parameter int ACK_TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                coin,
  input  logic [2:0]          sel,
  input  logic                cancel,
  input  logic                disp_ack,
  output logic                disp_req,
  output logic [PROD_W-1:0]   disp_prod,
  output logic [CREDIT_W-1:0] credit,
  output logic                change_pulse,
  output logic                coin_rej,
  output logic                busy
);

  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam int ACK_W  = $clog2(ACK_TIMEOUT + 1);

  localparam logic [IDLE_W-1:0]   IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [ACK_W-1:0]    ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [CREDIT_W-1:0] P0        = CREDIT_W'(PRICE0);
  localparam logic [CREDIT_W-1:0] P1        = CREDIT_W'(PRICE1);
  localparam logic [CREDIT_W-1:0] P2        = CREDIT_W'(PRICE2);

  state_t              r_state, w_state_nxt;
  logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
  logic [IDLE_W-1:0]   r_idle_cnt, w_idle_nxt;
  logic [ACK_W-1:0]    r_ack_cnt, w_ack_nxt;
  logic [PROD_W-1:0]   r_grant, w_grant_nxt;
  logic                r_phase, w_phase_nxt;
  logic                r_disp_req, w_req_nxt;
  logic                r_change, w_chg_nxt;
  logic                r_rej, w_rej_nxt;
  logic                r_coin_d;
  logic                r_armed;

  logic                w_busy;
  logic                w_coin_edge;
  logic                w_coin_ok;
  logic                w_gnt_vld;
  logic [PROD_W-1:0]   w_gnt;
  logic                w_upd;
  logic [CREDIT_W-1:0] w_price;

  rr_arbiter3 u_arb (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_ena     (ena),
    .i_req     (sel),
    .i_upd     (w_upd),
    .i_upd_idx (r_grant),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt     (w_gnt)
  );

  assign w_busy = (r_state == ST_CHECK) || (r_state == ST_DISPENSE) ||
                  (r_state == ST_CHANGE) || (r_state == ST_REFUND);

  // r_armed masks the first enabled cycle after reset so a coin already high is not an edge.
  assign w_coin_edge = coin & ~r_coin_d & r_armed;
  assign w_coin_ok   = w_coin_edge & ~w_busy & (r_credit != CREDIT_MAX);
  assign w_rej_nxt   = w_coin_edge & ~w_coin_ok;

  always_comb begin
    case (r_grant)
      2'd0:    w_price = P0;
      2'd1:    w_price = P1;
      default: w_price = P2;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    w_idle_nxt   = r_idle_cnt;
    w_ack_nxt    = r_ack_cnt;
    w_phase_nxt  = r_phase;
    w_req_nxt    = r_disp_req;
    w_grant_nxt  = r_grant;
    w_chg_nxt    = 1'b0;
    w_upd        = 1'b0;

    if (w_coin_ok) w_credit_nxt = sat_add(r_credit, CREDIT_W'(1));

    case (r_state)
      ST_IDLE: begin
        w_idle_nxt = '0;
        if (w_coin_ok) w_state_nxt = ST_CREDIT;
      end
      ST_CREDIT: begin
        if (cancel) begin
          w_state_nxt = ST_REFUND;
          w_idle_nxt  = '0;
          w_phase_nxt = 1'b0;
        end else if (w_gnt_vld) begin
          w_grant_nxt = w_gnt;
          w_state_nxt = ST_CHECK;
          w_idle_nxt  = '0;
        end else if (w_coin_edge) begin
          w_idle_nxt = '0;
        end else if (r_idle_cnt == IDLE_LAST) begin
          w_state_nxt = ST_REFUND;
          w_idle_nxt  = '0;
          w_phase_nxt = 1'b0;
        end else begin
          w_idle_nxt = r_idle_cnt + IDLE_W'(1);
        end
      end
      ST_CHECK: begin
        if (r_credit >= w_price) begin
          w_credit_nxt = sat_sub(r_credit, w_price);
          w_req_nxt    = 1'b1;
          w_ack_nxt    = '0;
          w_upd        = 1'b1;
          w_state_nxt  = ST_DISPENSE;
        end else begin
          w_state_nxt = ST_CREDIT;
        end
      end
      ST_DISPENSE: begin
        if (disp_ack) begin
          w_req_nxt   = 1'b0;
          w_ack_nxt   = '0;
          w_phase_nxt = 1'b0;
          w_state_nxt = (r_credit != '0) ? ST_CHANGE : ST_IDLE;
        end else if (r_ack_cnt == ACK_LAST) begin
          // Dispenser never answered: give the price back and refund everything.
          w_credit_nxt = sat_add(r_credit, w_price);
          w_req_nxt    = 1'b0;
          w_ack_nxt    = '0;
          w_phase_nxt  = 1'b0;
          w_state_nxt  = ST_REFUND;
        end else begin
          w_ack_nxt = r_ack_cnt + ACK_W'(1);
        end
      end
      ST_CHANGE, ST_REFUND: begin
        if (r_phase) begin
          w_phase_nxt = 1'b0;
        end else if (r_credit != '0) begin
          w_chg_nxt    = 1'b1;
          w_credit_nxt = sat_sub(r_credit, CREDIT_W'(1));
          w_phase_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_credit   <= '0;
      r_idle_cnt <= '0;
      r_ack_cnt  <= '0;
      r_grant    <= '0;
      r_phase    <= 1'b0;
      r_disp_req <= 1'b0;
      r_change   <= 1'b0;
      r_rej      <= 1'b0;
      r_coin_d   <= 1'b0;
      r_armed    <= 1'b0;
    end else if (ena) begin
      r_state    <= w_state_nxt;
      r_credit   <= w_credit_nxt;
      r_idle_cnt <= w_idle_nxt;
      r_ack_cnt  <= w_ack_nxt;
      r_grant    <= w_grant_nxt;
      r_phase    <= w_phase_nxt;
      r_disp_req <= w_req_nxt;
      r_change   <= w_chg_nxt;
      r_rej      <= w_rej_nxt;
      r_coin_d   <= coin;
      r_armed    <= 1'b1;
    end
  end

  assign disp_req     = r_disp_req;
  assign disp_prod    = r_grant;
  assign credit       = r_credit;
  assign busy         = w_busy;
  // A pulse held across a disabled stretch is masked, then seen once on resume.
  assign change_pulse = r_change & ena;
  assign coin_rej     = r_rej & ena;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer: a cycle-exact vector table for a basic
// vend / failed check / cancel, plus sequences for timeouts, RR order and reset.
module tb_vend_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       coin = 1'b0;
  logic [2:0] sel = 3'b000;
  logic       cancel = 1'b0;
  logic       disp_ack = 1'b0;
  logic       disp_req;
  logic [1:0] disp_prod;
  logic [2:0] credit;
  logic       change_pulse;
  logic       coin_rej;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  vend_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .coin         (coin),
    .sel          (sel),
    .cancel       (cancel),
    .disp_ack     (disp_ack),
    .disp_req     (disp_req),
    .disp_prod    (disp_prod),
    .credit       (credit),
    .change_pulse (change_pulse),
    .coin_rej     (coin_rej),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       coin;
    logic [2:0] sel;
    logic       cancel;
    logic       ack;
    logic [2:0] credit;
    logic       req;
    logic [1:0] prod;
    logic       busy;
    logic       chg;
    logic       rej;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(input logic c, input logic [2:0] s, input logic cn, input logic a,
                              input logic [2:0] cr, input logic rq, input logic [1:0] pd,
                              input logic b, input logic ch, input logic rj);
    vec_t v;
    v = {c, s, cn, a, cr, rq, pd, b, ch, rj};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic coins(input int n);
    for (int i = 0; i < n; i++) begin
      coin = 1'b1; step();
      coin = 1'b0; step();
    end
  endtask

  task automatic do_reset();
    coin = 1'b0; sel = 3'b000; cancel = 1'b0; disp_ack = 1'b0; ena = 1'b1;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step(); step();
  endtask

  // Runs until busy drops; counts change pulses and checks they never come back-to-back.
  task automatic drain(input string name, input int exp_pulses);
    int  cnt;
    logic prev;
    cnt  = 0;
    prev = 1'b0;
    for (int i = 0; i < 40 && busy; i++) begin
      step();
      if (change_pulse) begin
        cnt++;
        if (prev) chk({name, " alternate"}, 1, 0);
      end
      prev = change_pulse;
    end
    chk({name, " pulses"}, cnt, exp_pulses);
    chk({name, " credit end"}, credit, 0);
    chk({name, " busy end"}, busy, 0);
  endtask

  initial begin
    int   pc;
    int   rem;
    logic [2:0] prices [3];
    prices[0] = 3'd2; prices[1] = 3'd3; prices[2] = 3'd5;

    //             coin  sel     cncl  ack   credit req   prod   busy  chg   rej
    tbl[0]  = mk(1'b1, 3'b000, 1'b0, 1'b0, 3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 3'b000, 1'b0, 1'b0, 3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b1, 3'b000, 1'b0, 1'b0, 3'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 3'b000, 1'b0, 1'b0, 3'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 3'b000, 1'b0, 1'b0, 3'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(1'b0, 3'b000, 1'b0, 1'b0, 3'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(1'b0, 3'b010, 1'b0, 1'b0, 3'd3, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 3'b000, 1'b0, 1'b0, 3'd0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 3'b000, 1'b0, 1'b0, 3'd0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 3'b000, 1'b0, 1'b1, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk(1'b0, 3'b000, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tbl[11] = mk(1'b1, 3'b000, 1'b0, 1'b0, 3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tbl[12] = mk(1'b0, 3'b000, 1'b0, 1'b0, 3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tbl[13] = mk(1'b1, 3'b000, 1'b0, 1'b0, 3'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tbl[14] = mk(1'b0, 3'b000, 1'b0, 1'b0, 3'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tbl[15] = mk(1'b0, 3'b100, 1'b0, 1'b0, 3'd2, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    tbl[16] = mk(1'b1, 3'b000, 1'b0, 1'b0, 3'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    tbl[17] = mk(1'b1, 3'b111, 1'b1, 1'b0, 3'd2, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    tbl[18] = mk(1'b0, 3'b000, 1'b0, 1'b0, 3'd1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    tbl[19] = mk(1'b0, 3'b000, 1'b0, 1'b0, 3'd1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    tbl[20] = mk(1'b0, 3'b000, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    tbl[21] = mk(1'b0, 3'b000, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    tbl[22] = mk(1'b0, 3'b000, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    // Reset values while rst_n is low
    rst_n = 1'b0;
    #1;
    chk("rst credit", credit, 0);
    chk("rst disp_req", disp_req, 0);
    chk("rst disp_prod", disp_prod, 0);
    chk("rst busy", busy, 0);
    chk("rst change_pulse", change_pulse, 0);
    chk("rst coin_rej", coin_rej, 0);

    // Coin held high across reset release is not an edge
    coin = 1'b1;
    step(); step();
    rst_n = 1'b1;
    step(); step(); step();
    chk("held coin credit", credit, 0);
    chk("held coin busy", busy, 0);
    coin = 1'b0;
    step();

    // Vector table: 3-coin vend of product 1, failed check, cancel refund
    for (int i = 0; i < 23; i++) begin
      coin = tbl[i].coin; sel = tbl[i].sel; cancel = tbl[i].cancel; disp_ack = tbl[i].ack;
      step();
      chk($sformatf("vec%0d credit", i), credit, tbl[i].credit);
      chk($sformatf("vec%0d disp_req", i), disp_req, tbl[i].req);
      chk($sformatf("vec%0d busy", i), busy, tbl[i].busy);
      chk($sformatf("vec%0d change_pulse", i), change_pulse, tbl[i].chg);
      chk($sformatf("vec%0d coin_rej", i), coin_rej, tbl[i].rej);
      if (tbl[i].req) chk($sformatf("vec%0d disp_prod", i), disp_prod, tbl[i].prod);
    end
    coin = 1'b0; sel = 3'b000; cancel = 1'b0; disp_ack = 1'b0;

    // 7 coins, 8th rejected, ena hold, vend product 0, 5 change pulses
    do_reset();
    coins(7);
    chk("7coin credit", credit, 7);
    coin = 1'b1; step();
    chk("8th coin_rej", coin_rej, 1);
    chk("8th credit", credit, 7);
    ena = 1'b0;
    #1;
    chk("ena0 coin_rej forced", coin_rej, 0);
    coin = 1'b0; sel = 3'b001;
    step(); step(); step();
    chk("ena0 credit hold", credit, 7);
    chk("ena0 busy hold", busy, 0);
    ena = 1'b1;
    step();
    sel = 3'b000;
    step();
    chk("p0 credit", credit, 5);
    chk("p0 disp_req", disp_req, 1);
    chk("p0 disp_prod", disp_prod, 0);
    disp_ack = 1'b1; step(); disp_ack = 1'b0;
    chk("p0 req drop", disp_req, 0);
    drain("p0 change", 5);

    // Round-robin order over three vends at credit 7
    do_reset();
    for (int v = 0; v < 3; v++) begin
      coins(7);
      sel = 3'b111; step();
      sel = 3'b000; step();
      rem = 7 - int'(prices[v]);
      chk($sformatf("rr%0d disp_prod", v), disp_prod, v);
      chk($sformatf("rr%0d disp_req", v), disp_req, 1);
      chk($sformatf("rr%0d credit", v), credit, rem);
      disp_ack = 1'b1; step(); disp_ack = 1'b0;
      drain($sformatf("rr%0d change", v), rem);
    end

    // Ack timeout: price restored, full refund
    do_reset();
    coins(5);
    sel = 3'b001; step();
    sel = 3'b000; step();
    chk("to credit after check", credit, 3);
    for (int i = 0; i < 15; i++) step();
    chk("to req before timeout", disp_req, 1);
    step();
    chk("to req dropped", disp_req, 0);
    chk("to credit restored", credit, 5);
    chk("to busy refund", busy, 1);
    drain("to refund", 5);

    // Idle timeout: refund after 200 quiet cycles
    do_reset();
    coins(4);
    for (int i = 0; i < 198; i++) step();
    chk("idle 199 busy", busy, 0);
    step();
    chk("idle 200 busy", busy, 1);
    drain("idle refund", 4);

    // Reset during CHANGE discards credit with no further pulses
    do_reset();
    coins(5);
    sel = 3'b001; step();
    sel = 3'b000; step();
    disp_ack = 1'b1; step(); disp_ack = 1'b0;
    step();
    chk("chg first pulse", change_pulse, 1);
    chk("chg credit", credit, 2);
    rst_n = 1'b0;
    #1;
    chk("midrst credit", credit, 0);
    chk("midrst busy", busy, 0);
    chk("midrst pulse", change_pulse, 0);
    step();
    rst_n = 1'b1;
    pc = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (change_pulse) pc++;
    end
    chk("midrst no pulses", pc, 0);
    chk("midrst credit after", credit, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
